wb_commit_multi: RTL and testbench
==================================

Name: wb_commit_multi

Overview:
- Parametrised writeback/commit stage for an NUM_LANES-wide in-order backend; sits after the final execute stage and drives the register file write ports, CSR exception-capture inputs and difftest debug ports.
- Adds to the prior dual-lane writeback:
  - valid/allowin handshake with a memory-wait FSM;
  - precise per-bundle exception selection (oldest lane wins, younger lanes squashed);
  - a one-cycle post-exception flush window.

Parameters:
- NUM_LANES, 2, issue lanes per bundle (1..4); lane 0 is oldest.
- XLEN, 32, data/PC width.
- ECODE_W, 7, exception code width.
- ECODE_INT, 7'h00, ecode reported for an external interrupt.

Ports:
- clk  in  1  clock, rising edge.
- areset  in  1  reset, asynchronous and active-high.
- in_valid  in  NUM_LANES  per-lane instruction valid from execute.
- in_pc  in  NUM_LANES*XLEN  per-lane PC; lane i at [i*XLEN +: XLEN].
- in_inst  in  NUM_LANES*32  per-lane instruction word.
- in_we  in  NUM_LANES  lane writes rd.
- in_rd  in  NUM_LANES*5  destination register.
- in_data  in  NUM_LANES*XLEN  ALU/MUL/CSR result.
- in_mem  in  NUM_LANES  lane is a load/store needing a dcache response.
- in_exc  in  NUM_LANES  lane raised an exception.
- in_ecode  in  NUM_LANES*ECODE_W  exception code.
- in_badv  in  NUM_LANES*XLEN  bad virtual address.
- cpu_interrupt  in  1  pending enabled interrupt.
- mem_resp_valid  in  1  dcache response/ack for the waiting memory op.
- mem_resp_data  in  XLEN  load data (replaces in_data for the memory lane when in_we=1).
- wb_allowin  out  1  stage can accept the presented bundle this cycle.
- wb_we  out  NUM_LANES  register write enable.
- wb_rd  out  NUM_LANES*5  register index.
- wb_data  out  NUM_LANES*XLEN  write data.
- commit_valid  out  NUM_LANES  lane retired (debug).
- commit_pc  out  NUM_LANES*XLEN  retired PC (debug).
- commit_inst  out  NUM_LANES*32  retired instruction (debug).
- exc_valid  out  1  one-cycle exception/interrupt commit pulse.
- exc_ecode  out  ECODE_W  selected ecode.
- exc_era  out  XLEN  PC of the faulting lane.
- exc_badv  out  XLEN  badv of the faulting lane.
- flush_out  out  1  pipeline flush, equal to exc_valid.

Behaviour:
- Reset (async, areset=1): all outputs 0 except wb_allowin=0; FSM=IDLE. Deassertion takes effect at the next edge.

FSM states: IDLE, MEM_WAIT, FLUSH.

IDLE:
- wb_allowin=1 unless the bundle contains a non-excepting in_mem lane (lowest index m, older than any excepting lane) and mem_resp_valid=0; then wb_allowin=0 and the state moves to MEM_WAIT.
- Accept = wb_allowin & |in_valid. Registered outputs update on the accepting edge, giving 1-cycle latency.

MEM_WAIT:
- wb_allowin=0; inputs are held stable by upstream.
- On mem_resp_valid=1: wb_allowin=1 combinationally that cycle, the bundle is accepted, and the state returns to IDLE.
- Only lane m waits. Additional in_mem lanes in the same bundle are illegal (upstream guarantees at most one).

Exception selection on accept:
- k = lowest lane with in_valid & in_exc.
- If cpu_interrupt=1, k=lowest valid lane and ecode=ECODE_INT; interrupt overrides any lane exception.
- Lanes ≥ k: wb_we=0, commit_valid=0.
- Lanes < k commit normally.
- exc_valid=flush_out=1 for exactly one cycle with exc_era=pc[k], exc_ecode, exc_badv=badv[k]. Next state is FLUSH.

FLUSH:
- Lasts one cycle; wb_allowin=0 and all outputs are 0.
- Returns to IDLE unconditionally.

No accept: wb_we, commit_valid and exc_valid are 0 the next cycle. wb_rd and wb_data are also 0, so outputs carry no stale values.

Write-data rules:
- wb_we[i] = in_valid[i] & in_we[i] & not squashed & (in_rd[i]!=0).
- Lane m uses mem_resp_data when in_we[m].
- Stores commit with wb_we=0.

Simultaneous cases:
- mem_resp_valid in IDLE with an excepting older lane: the response is ignored and the exception wins.
- Interrupt during MEM_WAIT is sampled only on the accepting edge.

Optional Feature:
WB_PERF_CNT_EN:
- When defined, adds outputs perf_retired (32 bits, count of retired instructions; adds popcount(commit_valid) per cycle, wraps at 2^32), perf_mem_stall (32 bits, cycles spent in MEM_WAIT) and perf_flush (16 bits, exc_valid pulses, saturating at 16'hFFFF).
- All counters reset to 0 on areset.
- When undefined, these ports and logic are absent; other behaviour is identical.

Test Plan:
- NUM_LANES=2. Bundle lane0 {pc=0x1c000000, rd=4, data=0x11}, lane1 {pc=0x1c000004, rd=5, data=0x22} → next cycle wb_we=2'b11, wb_data lanes {0x11,0x22}, commit_valid=2'b11, exc_valid=0.
- Lane0 load rd=6, mem_resp_valid low for 3 cycles → wb_allowin=0 for 3 cycles. Then resp data 0xDEADBEEF → one cycle later wb_we[0]=1, wb_data[0]=0xDEADBEEF, FSM back to IDLE.
- Lane1 exc ecode=0x09, badv=0x1234, pc=0x1c000014; lane0 valid → lane0 commits, wb_we[1]=0, exc_valid=1 for one cycle, exc_era=0x1c000014, exc_badv=0x1234. Next cycle FLUSH with wb_allowin=0, then IDLE.
- Both lanes exc (ecode 0x08 / 0x09) → lane0 selected (ecode 0x08), commit_valid=2'b00.
- cpu_interrupt=1 with a valid bundle → exc_ecode=ECODE_INT, exc_era=lane0 pc, no lane commits. Also assert areset mid-MEM_WAIT → all outputs 0 immediately (async), FSM=IDLE.
- rd=0 with in_we=1 → wb_we=0 but commit_valid=1. With WB_PERF_CNT_EN: after the 2-lane bundle test, perf_retired=2.

Source files
------------

// File: rtl/wb_commit_multi.sv
// rtl/wb_commit_multi.sv - multi-lane writeback/commit stage with memory-wait FSM and precise exceptions
// Optional performance counters are enabled by defining WB_PERF_CNT_EN.
module wb_commit_multi #(
  parameter int                 NUM_LANES = 2,
  parameter int                 XLEN      = 32,
  parameter int                 ECODE_W   = 7,
  parameter logic [ECODE_W-1:0] ECODE_INT = {ECODE_W{1'b0}}
) (
  input  logic                          clk,
  input  logic                          areset,
  input  logic [NUM_LANES-1:0]          in_valid,
  input  logic [NUM_LANES*XLEN-1:0]     in_pc,
  input  logic [NUM_LANES*32-1:0]       in_inst,
  input  logic [NUM_LANES-1:0]          in_we,
  input  logic [NUM_LANES*5-1:0]        in_rd,
  input  logic [NUM_LANES*XLEN-1:0]     in_data,
  input  logic [NUM_LANES-1:0]          in_mem,
  input  logic [NUM_LANES-1:0]          in_exc,
  input  logic [NUM_LANES*ECODE_W-1:0]  in_ecode,
  input  logic [NUM_LANES*XLEN-1:0]     in_badv,
  input  logic                          cpu_interrupt,
  input  logic                          mem_resp_valid,
  input  logic [XLEN-1:0]               mem_resp_data,
  output logic                          wb_allowin,
  output logic [NUM_LANES-1:0]          wb_we,
  output logic [NUM_LANES*5-1:0]        wb_rd,
  output logic [NUM_LANES*XLEN-1:0]     wb_data,
  output logic [NUM_LANES-1:0]          commit_valid,
  output logic [NUM_LANES*XLEN-1:0]     commit_pc,
  output logic [NUM_LANES*32-1:0]       commit_inst,
  output logic                          exc_valid,
  output logic [ECODE_W-1:0]            exc_ecode,
  output logic [XLEN-1:0]               exc_era,
  output logic [XLEN-1:0]               exc_badv,
  output logic                          flush_out
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_retired,
  output logic [31:0]                   perf_mem_stall,
  output logic [15:0]                   perf_flush
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_MEM_WAIT, S_FLUSH} state_e;

  state_e                       state_q;
  logic [NUM_LANES-1:0]         wb_we_q, commit_valid_q;
  logic [NUM_LANES*5-1:0]       wb_rd_q;
  logic [NUM_LANES*XLEN-1:0]    wb_data_q, commit_pc_q;
  logic [NUM_LANES*32-1:0]      commit_inst_q;
  logic                         exc_valid_q;
  logic [ECODE_W-1:0]           exc_ecode_q;
  logic [XLEN-1:0]              exc_era_q, exc_badv_q;

  logic [NUM_LANES-1:0]         keep, mem_sel;
  logic                         exc_hit;
  logic [ECODE_W-1:0]           sel_ecode;
  logic [XLEN-1:0]              sel_era, sel_badv;
  logic                         allowin, accept;

  logic [NUM_LANES-1:0]         wb_we_d, commit_valid_d;
  logic [NUM_LANES*5-1:0]       wb_rd_d;
  logic [NUM_LANES*XLEN-1:0]    wb_data_d, commit_pc_d;
  logic [NUM_LANES*32-1:0]      commit_inst_d;

  // Walk lanes oldest-first: the first excepting lane (any valid lane on an
  // interrupt) stops the walk, so everything younger is squashed and only an
  // older memory lane can stall the bundle.
  always_comb begin
    keep      = '0;
    mem_sel   = '0;
    exc_hit   = 1'b0;
    sel_ecode = '0;
    sel_era   = '0;
    sel_badv  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!exc_hit) begin
        if (in_valid[i] && (cpu_interrupt || in_exc[i])) begin
          exc_hit   = 1'b1;
          sel_ecode = cpu_interrupt ? ECODE_INT : in_ecode[i*ECODE_W +: ECODE_W];
          sel_era   = in_pc[i*XLEN +: XLEN];
          sel_badv  = in_badv[i*XLEN +: XLEN];
        end else begin
          keep[i] = in_valid[i];
          if (in_valid[i] && in_mem[i] && (mem_sel == '0)) mem_sel[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    allowin = 1'b0;
    case (state_q)
      S_IDLE:     allowin = ~(|mem_sel) | mem_resp_valid;
      S_MEM_WAIT: allowin = mem_resp_valid;
      default:    allowin = 1'b0;
    endcase
  end

  assign accept     = allowin & (|in_valid);
  assign wb_allowin = allowin & ~areset;

  // Lanes that do not retire drive zeros so nothing stale leaks downstream.
  always_comb begin
    wb_we_d        = '0;
    wb_rd_d        = '0;
    wb_data_d      = '0;
    commit_valid_d = '0;
    commit_pc_d    = '0;
    commit_inst_d  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (accept && keep[i]) begin
        commit_valid_d[i]           = 1'b1;
        commit_pc_d[i*XLEN +: XLEN] = in_pc[i*XLEN +: XLEN];
        commit_inst_d[i*32 +: 32]   = in_inst[i*32 +: 32];
        wb_rd_d[i*5 +: 5]           = in_rd[i*5 +: 5];
        wb_data_d[i*XLEN +: XLEN]   = (mem_sel[i] && in_we[i]) ? mem_resp_data
                                                               : in_data[i*XLEN +: XLEN];
        wb_we_d[i]                  = in_we[i] && (in_rd[i*5 +: 5] != 5'd0);
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q        <= S_IDLE;
      wb_we_q        <= '0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      commit_valid_q <= '0;
      commit_pc_q    <= '0;
      commit_inst_q  <= '0;
      exc_valid_q    <= 1'b0;
      exc_ecode_q    <= '0;
      exc_era_q      <= '0;
      exc_badv_q     <= '0;
    end else begin
      wb_we_q        <= wb_we_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
      commit_inst_q  <= commit_inst_d;
      exc_valid_q    <= accept & exc_hit;
      exc_ecode_q    <= (accept && exc_hit) ? sel_ecode : '0;
      exc_era_q      <= (accept && exc_hit) ? sel_era   : '0;
      exc_badv_q     <= (accept && exc_hit) ? sel_badv  : '0;
      case (state_q)
        S_IDLE: begin
          if (accept)            state_q <= exc_hit ? S_FLUSH : S_IDLE;
          else if (|mem_sel)     state_q <= S_MEM_WAIT;
        end
        S_MEM_WAIT: begin
          if (accept)            state_q <= exc_hit ? S_FLUSH : S_IDLE;
        end
        default:                 state_q <= S_IDLE;
      endcase
    end
  end

  assign wb_we        = wb_we_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign commit_valid = commit_valid_q;
  assign commit_pc    = commit_pc_q;
  assign commit_inst  = commit_inst_q;
  assign exc_valid    = exc_valid_q;
  assign exc_ecode    = exc_ecode_q;
  assign exc_era      = exc_era_q;
  assign exc_badv     = exc_badv_q;
  assign flush_out    = exc_valid_q;

`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_retired_q, perf_mem_stall_q, retire_cnt;
  logic [15:0] perf_flush_q;

  always_comb begin
    retire_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) retire_cnt = retire_cnt + {31'd0, commit_valid_q[i]};
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      perf_retired_q   <= '0;
      perf_mem_stall_q <= '0;
      perf_flush_q     <= '0;
    end else begin
      perf_retired_q <= perf_retired_q + retire_cnt;
      if (state_q == S_MEM_WAIT) perf_mem_stall_q <= perf_mem_stall_q + 32'd1;
      if (exc_valid_q && (perf_flush_q != 16'hFFFF)) perf_flush_q <= perf_flush_q + 16'd1;
    end
  end

  assign perf_retired   = perf_retired_q;
  assign perf_mem_stall = perf_mem_stall_q;
  assign perf_flush     = perf_flush_q;
`endif

endmodule

// File: tb/tb_wb_commit_multi.sv
// tb/tb_wb_commit_multi.sv - vector table, hand sequences and random model checks for wb_commit_multi
module tb_wb_commit_multi;

  logic        clk = 1'b0;
  logic        areset;
  logic [1:0]  in_valid, in_we, in_mem, in_exc;
  logic [63:0] in_pc, in_data, in_badv, in_inst;
  logic [9:0]  in_rd;
  logic [13:0] in_ecode;
  logic        cpu_interrupt, mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        wb_allowin, exc_valid, flush_out;
  logic [1:0]  wb_we, commit_valid;
  logic [9:0]  wb_rd;
  logic [63:0] wb_data, commit_pc, commit_inst;
  logic [6:0]  exc_ecode;
  logic [31:0] exc_era, exc_badv;
`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_retired, perf_mem_stall;
  logic [15:0] perf_flush;
`endif

  wb_commit_multi #(.NUM_LANES(2), .XLEN(32), .ECODE_W(7), .ECODE_INT(7'h00)) dut (
    .clk(clk), .areset(areset), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_we(in_we), .in_rd(in_rd), .in_data(in_data), .in_mem(in_mem), .in_exc(in_exc),
    .in_ecode(in_ecode), .in_badv(in_badv), .cpu_interrupt(cpu_interrupt),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .wb_allowin(wb_allowin),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .commit_inst(commit_inst), .exc_valid(exc_valid),
    .exc_ecode(exc_ecode), .exc_era(exc_era), .exc_badv(exc_badv), .flush_out(flush_out)
`ifdef WB_PERF_CNT_EN
    , .perf_retired(perf_retired), .perf_mem_stall(perf_mem_stall), .perf_flush(perf_flush)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       we, cv;
    logic             exc, wait_mem;
    logic [6:0]       ecode;
    logic [31:0]      era, badv;
    logic [1:0][31:0] data;
  } exp_t;

  typedef struct {
    string            name;
    logic [1:0]       valid, we, mem, exc;
    logic             irq, resp_idle;
    logic [1:0][31:0] pc, data, badv;
    logic [1:0][4:0]  rd;
    logic [1:0][6:0]  ecode;
    logic [31:0]      mdata;
    int               lat;
    exp_t             ex;
  } vec_t;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, req);
  endtask

  function automatic vec_t blank(input string n);
    vec_t v;
    v.name = n; v.valid = '0; v.we = '0; v.mem = '0; v.exc = '0; v.irq = 1'b0;
    v.resp_idle = 1'b0; v.pc = '0; v.data = '0; v.badv = '0; v.rd = '0; v.ecode = '0;
    v.mdata = '0; v.lat = 0; v.ex = '0;
    return v;
  endfunction

  // Reference: find the oldest faulting lane by index arithmetic, retire everything older.
  function automatic exp_t model(input vec_t v);
    exp_t e;
    int k, m;
    e = '0;
    k = 2;
    for (int i = 0; i < 2; i++) if (k == 2 && v.valid[i] && (v.irq || v.exc[i])) k = i;
    m = -1;
    for (int i = 0; i < k; i++) if (m < 0 && v.valid[i] && v.mem[i]) m = i;
    e.exc = (k < 2);
    e.wait_mem = (m >= 0);
    if (e.exc) begin
      e.era   = v.pc[k];
      e.badv  = v.badv[k];
      e.ecode = v.irq ? 7'h00 : v.ecode[k];
    end
    for (int i = 0; i < 2; i++) begin
      if (v.valid[i] && i < k) begin
        e.cv[i]   = 1'b1;
        e.we[i]   = v.we[i] && (v.rd[i] != 5'd0);
        e.data[i] = (i == m && v.we[i]) ? v.mdata : v.data[i];
      end
    end
    return e;
  endfunction

  task automatic drive(input vec_t v);
    in_valid = v.valid; in_we = v.we; in_mem = v.mem; in_exc = v.exc;
    in_pc = v.pc; in_data = v.data; in_badv = v.badv; in_rd = v.rd; in_ecode = v.ecode;
    in_inst = {v.pc[1] ^ 32'h13, v.pc[0] ^ 32'h13};
    cpu_interrupt = v.irq; mem_resp_data = v.mdata;
  endtask

  task automatic drive_idle();
    in_valid = '0; in_exc = '0; in_mem = '0; cpu_interrupt = 1'b0; mem_resp_valid = 1'b0;
  endtask

  task automatic apply(input vec_t v, input exp_t e);
    @(negedge clk);
    drive(v);
    if (e.wait_mem) begin
      mem_resp_valid = (v.lat == 0);
      for (int c = 0; c < v.lat; c++) begin
        #1 chk({v.name, "_allowin_wait"}, wb_allowin, 1'b0);
        @(negedge clk);
      end
      mem_resp_valid = 1'b1;
    end else begin
      mem_resp_valid = v.resp_idle;
    end
    #1 chk({v.name, "_allowin"}, wb_allowin, 1'b1);
    @(posedge clk);
    #1;
    chk({v.name, "_we"}, wb_we, e.we);
    chk({v.name, "_commit"}, commit_valid, e.cv);
    chk({v.name, "_exc"}, {exc_valid, flush_out}, {e.exc, e.exc});
    for (int i = 0; i < 2; i++) begin
      if (e.we[i]) begin
        chk($sformatf("%s_data%0d", v.name, i), wb_data[i*32 +: 32], e.data[i]);
        chk($sformatf("%s_rd%0d", v.name, i), wb_rd[i*5 +: 5], v.rd[i]);
      end
      if (e.cv[i]) chk($sformatf("%s_pc%0d", v.name, i), commit_pc[i*32 +: 32], v.pc[i]);
    end
    if (e.exc) begin
      chk({v.name, "_ecode"}, exc_ecode, e.ecode);
      chk({v.name, "_era"}, exc_era, e.era);
      chk({v.name, "_badv"}, exc_badv, e.badv);
    end
    drive_idle();
    if (e.exc) begin
      @(negedge clk);
      chk({v.name, "_flush_allowin"}, wb_allowin, 1'b0);
    end
    @(posedge clk);
    #1;
    chk({v.name, "_quiet"}, {wb_we, commit_valid, exc_valid, flush_out}, '0);
    chk({v.name, "_quiet_data"}, wb_data, '0);
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    in_inst = '0;
    drive(blank("init"));
    drive_idle();
    repeat (2) @(negedge clk);
    chk("reset_allowin", wb_allowin, 1'b0);
    chk("reset_outs", {wb_we, commit_valid, exc_valid, flush_out, exc_ecode}, '0);
    chk("reset_data", wb_data, '0);
    areset = 1'b0;

    v = blank("dual"); v.valid = 2'b11; v.we = 2'b11;
    v.pc = {32'h1c000004, 32'h1c000000}; v.rd = {5'd5, 5'd4}; v.data = {32'h22, 32'h11};
    v.ex.we = 2'b11; v.ex.cv = 2'b11; v.ex.data = {32'h22, 32'h11};
    tbl.push_back(v);

    v = blank("load_wait"); v.valid = 2'b01; v.we = 2'b01; v.mem = 2'b01;
    v.pc[0] = 32'h1c000008; v.rd[0] = 5'd6; v.data[0] = 32'h55; v.mdata = 32'hDEADBEEF; v.lat = 3;
    v.ex.we = 2'b01; v.ex.cv = 2'b01; v.ex.data[0] = 32'hDEADBEEF; v.ex.wait_mem = 1'b1;
    tbl.push_back(v);

    v = blank("exc_lane1"); v.valid = 2'b11; v.we = 2'b11; v.exc = 2'b10;
    v.pc = {32'h1c000014, 32'h1c000010}; v.rd = {5'd8, 5'd7}; v.data = {32'h44, 32'h33};
    v.ecode[1] = 7'h09; v.badv[1] = 32'h1234;
    v.ex.we = 2'b01; v.ex.cv = 2'b01; v.ex.data[0] = 32'h33; v.ex.exc = 1'b1;
    v.ex.ecode = 7'h09; v.ex.era = 32'h1c000014; v.ex.badv = 32'h1234;
    tbl.push_back(v);

    v = blank("exc_both"); v.valid = 2'b11; v.exc = 2'b11;
    v.pc = {32'h1c000024, 32'h1c000020}; v.ecode = {7'h09, 7'h08}; v.badv = {32'hbbb, 32'haaa};
    v.ex.exc = 1'b1; v.ex.ecode = 7'h08; v.ex.era = 32'h1c000020; v.ex.badv = 32'haaa;
    tbl.push_back(v);

    v = blank("irq"); v.valid = 2'b11; v.we = 2'b11; v.irq = 1'b1; v.exc = 2'b10;
    v.pc = {32'h1c000034, 32'h1c000030}; v.rd = {5'd2, 5'd1}; v.ecode[1] = 7'h09;
    v.badv = {32'h77, 32'h66};
    v.ex.exc = 1'b1; v.ex.ecode = 7'h00; v.ex.era = 32'h1c000030; v.ex.badv = 32'h66;
    tbl.push_back(v);

    v = blank("rd_zero"); v.valid = 2'b01; v.we = 2'b01; v.pc[0] = 32'h1c000038;
    v.data[0] = 32'h99; v.ex.cv = 2'b01;
    tbl.push_back(v);

    v = blank("resp_vs_exc"); v.valid = 2'b11; v.exc = 2'b01; v.mem = 2'b10; v.resp_idle = 1'b1;
    v.pc = {32'h1c000044, 32'h1c000040}; v.ecode[0] = 7'h05; v.badv[0] = 32'h40;
    v.ex.exc = 1'b1; v.ex.ecode = 7'h05; v.ex.era = 32'h1c000040; v.ex.badv = 32'h40;
    tbl.push_back(v);

    v = blank("load_lane1_fast"); v.valid = 2'b11; v.we = 2'b11; v.mem = 2'b10;
    v.pc = {32'h1c00004c, 32'h1c000048}; v.rd = {5'd10, 5'd9}; v.data = {32'h77, 32'h66};
    v.mdata = 32'hCAFEF00D;
    v.ex.we = 2'b11; v.ex.cv = 2'b11; v.ex.data = {32'hCAFEF00D, 32'h66}; v.ex.wait_mem = 1'b1;
    tbl.push_back(v);

    v = blank("store"); v.valid = 2'b01; v.mem = 2'b01; v.lat = 1; v.mdata = 32'h123;
    v.pc[0] = 32'h1c000050; v.rd[0] = 5'd3;
    v.ex.cv = 2'b01; v.ex.wait_mem = 1'b1;
    tbl.push_back(v);

    v = blank("empty_irq"); v.irq = 1'b1; v.exc = 2'b11;
    tbl.push_back(v);

    foreach (tbl[i]) begin
      apply(tbl[i], tbl[i].ex);
`ifdef WB_PERF_CNT_EN
      if (i == 0) chk("perf_retired", perf_retired, 32'd2);
`endif
    end

    // Async reset clears freshly registered outputs before the next edge.
    @(negedge clk);
    drive(tbl[0]);
    @(posedge clk);
    #1 chk("pre_reset_commit", commit_valid, 2'b11);
    drive_idle();
    #1 areset = 1'b1;
    #1 chk("async_reset_outs", {wb_we, commit_valid, exc_valid}, '0);
    chk("async_reset_data", wb_data, '0);
    chk("async_reset_allowin", wb_allowin, 1'b0);
    @(negedge clk);
    areset = 1'b0;

    // Reset in the middle of a memory wait returns the FSM to IDLE.
    @(negedge clk);
    drive(tbl[1]);
    mem_resp_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("memwait_allowin", wb_allowin, 1'b0);
    areset = 1'b1;
    #1 chk("memwait_reset_allowin", wb_allowin, 1'b0);
    chk("memwait_reset_outs", {wb_we, commit_valid, exc_valid, flush_out}, '0);
    @(negedge clk);
    areset = 1'b0;
    drive_idle();
    #1 chk("post_reset_idle_allowin", wb_allowin, 1'b1);

    for (int n = 0; n < 300; n++) begin
      v = blank("rand");
      v.valid = 2'($urandom);
      v.we = 2'($urandom);
      v.exc = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      v.irq = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0: v.mem = 2'b00;
        1: v.mem = 2'b01;
        default: v.mem = 2'b10;
      endcase
      for (int i = 0; i < 2; i++) begin
        v.pc[i] = 32'h1c000000 + 32'($urandom_range(0, 4095)) * 4;
        v.data[i] = $urandom;
        v.badv[i] = $urandom;
        v.rd[i] = 5'($urandom_range(0, 7));
        v.ecode[i] = 7'($urandom_range(1, 63));
      end
      v.mdata = $urandom;
      v.lat = $urandom_range(0, 3);
      v.resp_idle = 1'($urandom);
      apply(v, model(v));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
